chip_jkff_checker: RTL

CHIP_JKFF_CHECKER -- requirements
Module: chip_jkff_checker

---
 rtl/chip_jkff_checker.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/chip_jkff_checker.sv
// Sequencer that drives a fixed J-Kbar vector table into CHANNELS flip-flops and flags any Q/Qbar mismatch.
// Optional first-failure capture (FAIL_CH, FAIL_STEP) is built when CHIP_ERR_CAPTURE_EN is defined.
module chip_jkff_checker #(
  parameter int CHANNELS = 2,
  parameter int SETTLE   = 4,
  parameter int PASSES   = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Run,
  input  logic                DISP_RSLT,
  output logic [CHANNELS-1:0] CLR_n,
  output logic [CHANNELS-1:0] PRE_n,
  output logic [CHANNELS-1:0] J,
  output logic [CHANNELS-1:0] Kbar,
  output logic [CHANNELS-1:0] CK,
  input  logic [CHANNELS-1:0] Q,
  input  logic [CHANNELS-1:0] Qbar,
  output logic                Done,
  output logic                RSLT
`ifdef CHIP_ERR_CAPTURE_EN
  ,
  output logic [CHANNELS-1:0] FAIL_CH,
  output logic [2:0]          FAIL_STEP
`endif
);

  // state  | meaning
  // IDLE   | pins idle, waiting for Run
  // APPLY  | step pins driven with CK low, SETTLE cycles
  // CK_HI  | CK high on clocked steps 2..7, SETTLE cycles
  // SAMPLE | compare Q/Qbar against expected value
  // NEXT   | release CK/CLR_n/PRE_n, advance step and pass count
  // FINISH | Done high until Run drops
  typedef enum logic [2:0] {IDLE, APPLY, CK_HI, SAMPLE, NEXT, FINISH} state_t;

  localparam logic [7:0] TMR_LOAD  = 8'(SETTLE - 1);
  localparam logic [3:0] PASS_LAST = 4'(PASSES - 1);
  // Expected Q per step, bit n = step n
  localparam logic [7:0] EXP_Q     = 8'b0110_1010;

  state_t        state, state_nxt;
  logic [2:0]    step, step_nxt;
  logic [3:0]    pass_cnt, pass_nxt;
  logic [7:0]    tmr, tmr_nxt;
  logic          pass_flag, flag_nxt;
  logic [CHANNELS-1:0] bad;
  logic [CHANNELS-1:0] clr_d, pre_d, j_d, kbar_d, ck_d;
  logic          exp_q;

  assign exp_q = EXP_Q[step];
  assign bad   = (Q ^ {CHANNELS{exp_q}}) | ~(Q ^ Qbar);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      step      <= '0;
      pass_cnt  <= '0;
      tmr       <= '0;
      pass_flag <= 1'b0;
    end else begin
      state     <= state_nxt;
      step      <= step_nxt;
      pass_cnt  <= pass_nxt;
      tmr       <= tmr_nxt;
      pass_flag <= flag_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    pass_nxt  = pass_cnt;
    tmr_nxt   = tmr;
    flag_nxt  = pass_flag;
    case (state)
      IDLE: begin
        if (Run) begin
          state_nxt = APPLY;
          step_nxt  = '0;
          pass_nxt  = '0;
          tmr_nxt   = TMR_LOAD;
          flag_nxt  = 1'b1;
        end
      end
      APPLY: begin
        if (tmr == '0) begin
          if (step < 3'd2) begin
            state_nxt = SAMPLE;
          end else begin
            state_nxt = CK_HI;
            tmr_nxt   = TMR_LOAD;
          end
        end else begin
          tmr_nxt = tmr - 8'd1;
        end
      end
      CK_HI: begin
        if (tmr == '0) state_nxt = SAMPLE;
        else           tmr_nxt   = tmr - 8'd1;
      end
      SAMPLE: begin
        if (|bad) flag_nxt = 1'b0;
        state_nxt = NEXT;
      end
      NEXT: begin
        tmr_nxt   = TMR_LOAD;
        state_nxt = APPLY;
        step_nxt  = step + 3'd1;
        if (step == 3'd7) begin
          if (pass_cnt == PASS_LAST) state_nxt = FINISH;
          else                       pass_nxt  = pass_cnt + 4'd1;
        end
      end
      FINISH: begin
        if (!Run) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pins are decoded from the next state so the registered CK/CLR_n/PRE_n never glitch
  always_comb begin
    clr_d  = '1;
    pre_d  = '1;
    j_d    = '0;
    kbar_d = '1;
    ck_d   = '0;
    if (state_nxt == APPLY || state_nxt == CK_HI || state_nxt == SAMPLE ||
        state_nxt == NEXT) begin
      case (step_nxt)
        3'd2:       kbar_d = '0;
        3'd3:       j_d    = '1;
        3'd4, 3'd5: begin j_d = '1; kbar_d = '0; end
        3'd7:       kbar_d = '0;
        default:    ;
      endcase
      if (state_nxt != NEXT) begin
        if (step_nxt == 3'd0) clr_d = '0;
        if (step_nxt == 3'd1) pre_d = '0;
        if (state_nxt != APPLY && step_nxt >= 3'd2) ck_d = '1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      CLR_n <= '1;
      PRE_n <= '1;
      J     <= '0;
      Kbar  <= '1;
      CK    <= '0;
      Done  <= 1'b0;
    end else begin
      CLR_n <= clr_d;
      PRE_n <= pre_d;
      J     <= j_d;
      Kbar  <= kbar_d;
      CK    <= ck_d;
      Done  <= (state_nxt == FINISH);
    end
  end

  assign RSLT = Done & DISP_RSLT & pass_flag;

`ifdef CHIP_ERR_CAPTURE_EN
  // pass_flag still high means this is the first mismatching SAMPLE of the run
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      FAIL_CH   <= '0;
      FAIL_STEP <= '0;
    end else if (state == IDLE && Run) begin
      FAIL_CH   <= '0;
      FAIL_STEP <= '0;
    end else if (state == SAMPLE && pass_flag && |bad) begin
      FAIL_CH   <= bad;
      FAIL_STEP <= step;
    end
  end
`endif

endmodule
